// File: rtl/btn_debounce_multi.sv
// Multi-channel counter-based button debouncer: synchroniser, stability counter, press/release pulses.
// Optional auto-repeat (IDLE/HOLD/REPEAT per channel) is built when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_multi #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 1000,
    parameter int SYNC_STAGES   = 2,
    parameter int INVERT_IN     = 0,
    parameter int HOLD_CYCLES   = 50000,
    parameter int REPEAT_CYCLES = 10000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] raw_btn,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_repeat
);

    localparam int            CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic          INV      = (INVERT_IN != 0);

`ifdef BTN_AUTOREPEAT_EN
    localparam int            HMAX      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int            HW        = $clog2(HMAX + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;
`endif

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_ff;
            logic                   sync;
            logic [CW-1:0]          cnt;
            logic                   level_q;
            logic                   press_q;
            logic                   release_q;
            logic                   flip;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_ff <= '0;
                end else begin
                    sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw_btn[i]};
                end
            end

            assign sync = sync_ff[SYNC_STAGES-1] ^ INV;
            // The level flips on the STABLE_CYCLES-th consecutive disagreeing cycle.
            assign flip = (sync != level_q) && (cnt == CNT_LAST);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt       <= '0;
                    level_q   <= 1'b0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                end else begin
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                    if (sync == level_q) begin
                        cnt <= '0;
                    end else if (flip) begin
                        level_q   <= sync;
                        cnt       <= '0;
                        press_q   <= sync;
                        release_q <= ~sync;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end

            assign btn_level[i]   = level_q;
            assign btn_press[i]   = press_q;
            assign btn_release[i] = release_q;

`ifdef BTN_AUTOREPEAT_EN
            logic [1:0]    rpt_state;
            logic [HW-1:0] hcnt;
            logic          rpt_q;
            logic          rise_evt;
            logic          fall_evt;

            assign rise_evt = flip & sync;
            assign fall_evt = flip & ~sync;

            // HOLD is entered on the same edge that raises btn_press, so the hold count
            // is aligned with the press pulse; a falling level always wins over a repeat match.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rpt_state <= ST_IDLE;
                    hcnt      <= '0;
                    rpt_q     <= 1'b0;
                end else begin
                    rpt_q <= 1'b0;
                    if (rise_evt) begin
                        rpt_state <= ST_HOLD;
                        hcnt      <= '0;
                    end else if (!level_q || fall_evt) begin
                        rpt_state <= ST_IDLE;
                        hcnt      <= '0;
                    end else begin
                        case (rpt_state)
                            ST_HOLD: begin
                                if (hcnt == HOLD_LAST) begin
                                    rpt_q     <= 1'b1;
                                    hcnt      <= '0;
                                    rpt_state <= ST_REPEAT;
                                end else begin
                                    hcnt <= hcnt + HW'(1);
                                end
                            end
                            ST_REPEAT: begin
                                if (hcnt == REP_LAST) begin
                                    rpt_q <= 1'b1;
                                    hcnt  <= '0;
                                end else begin
                                    hcnt <= hcnt + HW'(1);
                                end
                            end
                            default: begin
                                rpt_state <= ST_IDLE;
                                hcnt      <= '0;
                            end
                        endcase
                    end
                end
            end

            assign btn_repeat[i] = rpt_q;
`else
            assign btn_repeat[i] = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi (4 channels, 4-cycle stability, 2-stage sync, hold 8 / repeat 3).
// Repeat expectations follow BTN_AUTOREPEAT_EN; without it btn_repeat must stay 0.
module tb_btn_debounce_multi;

    logic       clk;
    logic       rst_n;
    logic [3:0] raw_btn;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_repeat;

    int total_cnt = 0;
    int bad_cnt   = 0;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    btn_debounce_multi #(
        .CHANNELS     (4),
        .STABLE_CYCLES(4),
        .SYNC_STAGES  (2),
        .INVERT_IN    (0),
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_btn    (raw_btn),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int k, input logic [3:0] el,
                           input logic [3:0] ep, input logic [3:0] er, input logic [3:0] erep);
        string t;
        t = $sformatf("%s[%0d]", tag, k);
        chk({t, "_level"},   btn_level,   el);
        chk({t, "_press"},   btn_press,   ep);
        chk({t, "_release"}, btn_release, er);
        chk({t, "_repeat"},  btn_repeat,  erep);
    endtask

    int bpat[8] = '{1, 1, 1, 0, 1, 1, 1, 0};

    initial begin
        rst_n   = 1'b0;
        raw_btn = 4'b0000;
        tick(3);
        chk_all("reset", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        tick(1);

        // Clean press on ch0, held long enough to see the repeat train.
        raw_btn[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            chk_all("press0", k, (k >= 6) ? 4'b0001 : 4'b0000, (k == 6) ? 4'b0001 : 4'b0000,
                    4'b0000, (AR && (k == 14 || k == 17 || k == 20)) ? 4'b0001 : 4'b0000);
        end
        // Release ch0: one repeat still due while level is high; the one on the fall edge is dropped.
        raw_btn[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            chk_all("rel0", k, (k < 6) ? 4'b0001 : 4'b0000, 4'b0000,
                    (k == 6) ? 4'b0001 : 4'b0000, (AR && k == 3) ? 4'b0001 : 4'b0000);
        end

        // Bounce on ch1: mismatch runs of 3 never flip the level.
        for (int j = 0; j < 8; j++) begin
            raw_btn[1] = (bpat[j] != 0);
            tick(1);
            chk_all("bounce1", j, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        raw_btn[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            chk_all("steady1", k, (k >= 6) ? 4'b0010 : 4'b0000, (k == 6) ? 4'b0010 : 4'b0000,
                    4'b0000, 4'b0000);
        end

        // Press then release ch2 while ch1 stays held and repeating.
        raw_btn[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            chk_all("press2", k, (k >= 6) ? 4'b0110 : 4'b0010, (k == 6) ? 4'b0100 : 4'b0000,
                    4'b0000, (AR && k == 6) ? 4'b0010 : 4'b0000);
        end
        raw_btn[2] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            chk_all("rel2", k, (k < 6) ? 4'b0110 : 4'b0010, 4'b0000,
                    (k == 6) ? 4'b0100 : 4'b0000, (AR && (k == 3 || k == 6)) ? 4'b0010 : 4'b0000);
        end
        raw_btn = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            chk_all("rel1", k, (k < 6) ? 4'b0010 : 4'b0000, 4'b0000,
                    (k == 6) ? 4'b0010 : 4'b0000, (AR && (k == 1 || k == 4)) ? 4'b0010 : 4'b0000);
        end

        // All channels at once.
        raw_btn = 4'b1111;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            chk_all("all_on", k, (k >= 6) ? 4'b1111 : 4'b0000, (k == 6) ? 4'b1111 : 4'b0000,
                    4'b0000, 4'b0000);
        end
        // Fall lands on the first hold match, so no repeat appears.
        raw_btn = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            chk_all("all_off", k, (k < 6) ? 4'b1111 : 4'b0000, 4'b0000,
                    (k == 6) ? 4'b1111 : 4'b0000, 4'b0000);
        end

        // Reset mid-count on ch3 with ch1 already high.
        raw_btn = 4'b0010;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            chk_all("pre1", k, (k >= 6) ? 4'b0010 : 4'b0000, (k == 6) ? 4'b0010 : 4'b0000,
                    4'b0000, 4'b0000);
        end
        raw_btn = 4'b1010;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            chk_all("count3", k, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        end
        rst_n = 1'b0;
        #1;
        chk_all("rst_async", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick(2);
        chk_all("rst_hold", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            chk_all("post_rst", k, (k >= 6) ? 4'b1010 : 4'b0000, (k == 6) ? 4'b1010 : 4'b0000,
                    4'b0000, 4'b0000);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
